// File: rtl/pci_pkg.sv
// pci_pkg: shared PCI types and constants for arbiter and devices.
// Holds the arbiter state enum, timer defaults, device map and C/BE codes.
package pci_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  localparam int DEF_GNT_TIMEOUT = 16;
  localparam int DEF_LAT_TIMER   = 8;

  localparam logic [31:0] DEV0_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEV1_ADDR = 32'h1000_1000;
  localparam logic [31:0] DEV2_ADDR = 32'h1000_2000;
  localparam logic [31:0] DEV3_ADDR = 32'h1000_3000;

  localparam logic [3:0] CBE_READ  = 4'b0110;
  localparam logic [3:0] CBE_WRITE = 4'b0111;

endpackage

// File: rtl/pci_rr_picker.sv
// pci_rr_picker: combinational round-robin search over active-low requests.
// Ports: req (active low), last_idx in; valid, idx (first low req after last_idx) out.
module pci_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_idx,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  // Walk last_idx+1 .. last_idx+NUM_REQ (mod NUM_REQ); the
  // previous winner is examined last, giving it lowest priority.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_idx) + k) % NUM_REQ);
      if (!valid && !req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// pci_arbiter: central round-robin PCI arbiter, at most one active-low GNT.
// Ports: clk, rst_n, REQ, FRAME, IRDY in; GNT, grant_idx, bus_busy out.
// Option: define PCI_ARB_LATENCY_TIMER_EN to pull GNT early on long bursts.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter int LAT_TIMER   = DEF_LAT_TIMER
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic                       FRAME,
  input  logic                       IRDY,
  output logic [NUM_REQ-1:0]         GNT,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       bus_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = 16;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] req_q;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               frame_q;
  logic               busy_q;
  logic [CW-1:0]      cnt_q, cnt_d;

`ifdef PCI_ARB_LATENCY_TIMER_EN
  logic [CW-1:0]      lat_q, lat_d;
  logic [NUM_REQ-1:0] oth;
`endif

  pci_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req      (req_q),
    .last_idx (last_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Bus inputs are registered once; every decision works on the
  // sampled copies, so a grant follows the sampling edge by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '1;
      idx_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      req_q   <= '1;
      frame_q <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      req_q   <= REQ;
      frame_q <= FRAME;
      busy_q  <= ~(FRAME & IRDY);
      cnt_q   <= cnt_d;
    end
  end

`ifdef PCI_ARB_LATENCY_TIMER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else begin
      lat_q <= lat_d;
    end
  end

  always_comb begin
    oth        = ~req_q;
    oth[idx_q] = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef PCI_ARB_LATENCY_TIMER_EN
    lat_d   = lat_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = '1;
        cnt_d = '0;
        if (pick_valid) begin
          gnt_d   = ~(NUM_REQ'(1) << pick_idx);
          idx_d   = pick_idx;
          last_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!frame_q) begin
          state_d = BUSY;
`ifdef PCI_ARB_LATENCY_TIMER_EN
          // FRAME was sampled one edge before BUSY entry.
          lat_d   = CW'(1);
`endif
        end else if (req_q[idx_q]) begin
          gnt_d   = '1;
          state_d = IDLE;
        end else if (cnt_q == CW'(GNT_TIMEOUT - 1)) begin
          // last_idx already points here, so the
          // rotation moves past this device next.
          gnt_d   = '1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BUSY: begin
`ifdef PCI_ARB_LATENCY_TIMER_EN
        if (lat_q != CW'(LAT_TIMER)) begin
          lat_d = lat_q + CW'(1);
        end
        if (lat_q >= CW'(LAT_TIMER - 1) && |oth) begin
          gnt_d = '1;
        end
`endif
        if (!busy_q && frame_q) begin
          gnt_d   = '1;
          state_d = TURN;
        end
      end
      TURN: begin
        gnt_d   = '1;
        state_d = IDLE;
      end
    endcase
  end

  assign GNT       = gnt_q;
  assign grant_idx = idx_q;
  assign bus_busy  = busy_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: self-checking bench for pci_arbiter (NUM_REQ=4).
// Grant order is predicted from the round-robin rule on a request set.
module tb_pci_arbiter;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  REQ;
  logic          FRAME;
  logic          IRDY;
  logic [N-1:0]  GNT;
  logic [IW-1:0] grant_idx;
  logic          bus_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int model_last;

  always #5 clk = ~clk;

  pci_arbiter #(
    .NUM_REQ     (N),
    .GNT_TIMEOUT (16),
    .LAT_TIMER   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .REQ       (REQ),
    .FRAME     (FRAME),
    .IRDY      (IRDY),
    .GNT       (GNT),
    .grant_idx (grant_idx),
    .bus_busy  (bus_busy)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if ($countones(~GNT) > 1) begin
        n_bad++;
        $display("FAIL onehot: GNT=%b has more than one low bit", GNT);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot_n(input int i);
    return ~(N'(1) << i);
  endfunction

  // First requester strictly after the previous winner, wrapping.
  function automatic int rr_next(input logic [N-1:0] rq, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (rq[c[IW-1:0]] == 1'b0) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    REQ   = '1;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    cyc();
    rst_n      = 1'b1;
    model_last = N - 1;
  endtask

  task automatic wait_grant(input string nm, input int bound,
                            output int who, output int lat);
    who = -1;
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      cyc();
      if (GNT != '1) begin
        lat = i;
        for (int b = 0; b < N; b++)
          if (GNT == onehot_n(b)) who = b;
        break;
      end
    end
    if (who < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no single grant in %0d cycles, GNT=%b",
               nm, bound, GNT);
    end
  endtask

  // Granted master runs nd data phases, then the bus goes idle.
  task automatic run_xfer(input string nm, input int who, input int nd);
    cyc();
    FRAME = 1'b0;
    IRDY  = 1'b0;
    repeat (nd) cyc();
    FRAME = 1'b1;
    cyc();
    IRDY = 1'b1;
    cyc();
    n_cmp++;
    if (GNT !== onehot_n(who)) begin
      n_bad++;
      $display("FAIL %s_hold: GNT=%b want %b", nm, GNT, onehot_n(who));
    end
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111) begin
      n_bad++;
      $display("FAIL %s_release: GNT=%b want 1111", nm, GNT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    REQ   = '1;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_gnt: GNT=%b want 1111", GNT);
    end
    n_cmp++;
    if (grant_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_idx: grant_idx=%0d want 0", grant_idx);
    end
    n_cmp++;
    if (bus_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: bus_busy=%b want 0", bus_busy);
    end
    REQ = 4'b0000;
    cyc();
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_hold: GNT=%b want 1111", GNT);
    end
    REQ        = '1;
    rst_n      = 1'b1;
    model_last = N - 1;
    cyc();
  endtask

  task automatic test_basic();
    REQ = 4'b1110;
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111) begin
      n_bad++;
      $display("FAIL basic_early: GNT=%b want 1111", GNT);
    end
    cyc();
    n_cmp++;
    if (GNT !== 4'b1110 || grant_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL basic_grant: GNT=%b idx=%0d want 1110 idx 0",
               GNT, grant_idx);
    end
    model_last = 0;
    cyc();
    FRAME = 1'b0;
    IRDY  = 1'b0;
    cyc();
    n_cmp++;
    if (bus_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy: bus_busy=%b want 1", bus_busy);
    end
    REQ   = 4'b1111;
    FRAME = 1'b1;
    cyc();
    IRDY = 1'b1;
    cyc();
    n_cmp++;
    if (GNT !== 4'b1110) begin
      n_bad++;
      $display("FAIL basic_hold: GNT=%b want 1110", GNT);
    end
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111 || bus_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_release: GNT=%b busy=%b want 1111 0",
               GNT, bus_busy);
    end
    cyc();
    cyc();
  endtask

  task automatic test_round_robin();
    int who, lat, exp;
    do_reset();
    REQ = 4'b0000;
    for (int r = 0; r < 5; r++) begin
      exp = rr_next(REQ, model_last);
      wait_grant("rr", 6, who, lat);
      n_cmp++;
      if (who != exp || lat != 2 || grant_idx !== IW'(exp)) begin
        n_bad++;
        $display("FAIL rr_order: round %0d dev=%0d lat=%0d idx=%0d want dev %0d lat 2",
                 r, who, lat, grant_idx, exp);
      end
      model_last = exp;
      if (who >= 0) run_xfer("rr", who, 1);
      if (r == 4) REQ = '1;
    end
    cyc();
    cyc();
  endtask

  task automatic test_random();
    int who, lat, exp, d, nd;
    logic [N-1:0] rq;
    for (int r = 0; r < 25; r++) begin
      d   = int'($urandom_range(0, 3));
      nd  = int'($urandom_range(1, 4));
      rq  = ~N'($urandom_range(1, 15));
      REQ = '1;
      repeat (d) cyc();
      if (d > 0) begin
        n_cmp++;
        if (GNT !== 4'b1111) begin
          n_bad++;
          $display("FAIL rand_park: GNT=%b want 1111", GNT);
        end
      end
      REQ = rq;
      exp = rr_next(rq, model_last);
      wait_grant("rand", 6, who, lat);
      n_cmp++;
      if (who != exp || lat != 2) begin
        n_bad++;
        $display("FAIL rand_pick: req=%b dev=%0d lat=%0d want dev %0d lat 2",
                 rq, who, lat, exp);
      end
      model_last = exp;
      if (who >= 0) run_xfer("rand", who, nd);
    end
    REQ = '1;
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    int who, lat, exp, low;
    do_reset();
    REQ = 4'b1011;
    exp = rr_next(REQ, model_last);
    wait_grant("to_grant", 6, who, lat);
    n_cmp++;
    if (who != exp) begin
      n_bad++;
      $display("FAIL to_grant: dev=%0d want %0d", who, exp);
    end
    model_last = exp;
    low = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) REQ = 4'b0011;
      cyc();
      if (GNT != '1) low++;
      else break;
    end
    n_cmp++;
    if (low != 16) begin
      n_bad++;
      $display("FAIL to_len: GNT low %0d cycles want 16", low);
    end
    exp = rr_next(REQ, model_last);
    cyc();
    n_cmp++;
    if (GNT !== onehot_n(exp)) begin
      n_bad++;
      $display("FAIL to_skip: GNT=%b want %b", GNT, onehot_n(exp));
    end
    model_last = exp;
    REQ = '1;
    cyc();
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111) begin
      n_bad++;
      $display("FAIL to_drop: GNT=%b want 1111", GNT);
    end
  endtask

  task automatic test_abandon();
    int who, lat, exp;
    REQ = 4'b1101;
    exp = rr_next(REQ, model_last);
    wait_grant("ab_grant", 6, who, lat);
    n_cmp++;
    if (who != exp || lat != 2) begin
      n_bad++;
      $display("FAIL ab_grant: dev=%0d lat=%0d want dev %0d lat 2",
               who, lat, exp);
    end
    model_last = exp;
    REQ = 4'b1110;
    cyc();
    n_cmp++;
    if (GNT !== onehot_n(exp)) begin
      n_bad++;
      $display("FAIL ab_sample: GNT=%b want %b", GNT, onehot_n(exp));
    end
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111 || grant_idx !== IW'(exp)) begin
      n_bad++;
      $display("FAIL ab_release: GNT=%b idx=%0d want 1111 idx %0d",
               GNT, grant_idx, exp);
    end
    exp = rr_next(REQ, model_last);
    cyc();
    n_cmp++;
    if (GNT !== onehot_n(exp)) begin
      n_bad++;
      $display("FAIL ab_idle_regrant: GNT=%b want %b", GNT, onehot_n(exp));
    end
    model_last = exp;
    REQ = '1;
    repeat (3) cyc();
  endtask

  task automatic test_burst();
    int who, lat, low, other, want_low;
`ifdef PCI_ARB_LATENCY_TIMER_EN
    want_low = 8;
`else
    want_low = 12;
`endif
    do_reset();
    REQ = 4'b1110;
    wait_grant("burst_grant", 6, who, lat);
    n_cmp++;
    if (who != 0) begin
      n_bad++;
      $display("FAIL burst_grant: dev=%0d want 0", who);
    end
    REQ = 4'b1100;
    cyc();
    FRAME = 1'b0;
    IRDY  = 1'b0;
    low   = 0;
    other = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (GNT == 4'b1110) low++;
      else if (GNT != 4'b1111) other++;
    end
    n_cmp++;
    if (low != want_low || other != 0) begin
      n_bad++;
      $display("FAIL burst_len: GNT0 low %0d cycles other=%0d want %0d 0",
               low, other, want_low);
    end
    FRAME = 1'b1;
    cyc();
    IRDY = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (GNT !== 4'b1111) begin
      n_bad++;
      $display("FAIL burst_release: GNT=%b want 1111", GNT);
    end
    wait_grant("burst_next", 6, who, lat);
    n_cmp++;
    if (who != 1 || lat != 2) begin
      n_bad++;
      $display("FAIL burst_next: dev=%0d lat=%0d want dev 1 lat 2",
               who, lat);
    end
    REQ = '1;
    repeat (4) cyc();
  endtask

  task automatic test_async_reset();
    int who, lat, exp;
    do_reset();
    REQ = 4'b0111;
    exp = rr_next(REQ, model_last);
    wait_grant("ar_grant", 6, who, lat);
    cyc();
    FRAME = 1'b0;
    IRDY  = 1'b0;
    cyc();
    cyc();
    cyc();
    n_cmp++;
    if (GNT !== onehot_n(exp) || exp != 3) begin
      n_bad++;
      $display("FAIL ar_busy: GNT=%b dev %0d want 0111", GNT, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (GNT !== 4'b1111 || grant_idx !== 2'd0 || bus_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_async: GNT=%b idx=%0d busy=%b want 1111 0 0",
               GNT, grant_idx, bus_busy);
    end
    FRAME = 1'b1;
    IRDY  = 1'b1;
    REQ   = 4'b0000;
    cyc();
    rst_n      = 1'b1;
    model_last = N - 1;
    exp = rr_next(REQ, model_last);
    wait_grant("ar_first", 6, who, lat);
    n_cmp++;
    if (who != exp || lat != 2) begin
      n_bad++;
      $display("FAIL ar_first: dev=%0d lat=%0d want dev %0d lat 2",
               who, lat, exp);
    end
    REQ = '1;
    repeat (4) cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    REQ   = '1;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    model_last = N - 1;
    test_reset();
    test_basic();
    test_round_robin();
    test_random();
    test_timeout();
    test_abandon();
    test_burst();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pci_arbiter.md
# pci_arbiter

Central PCI bus arbiter for the shared AD/C_BE/FRAME/IRDY/TRDY/DEVSEL bus. Samples every device's active-low REQ, issues at most one active-low GNT using round-robin priority, and tracks FRAME/IRDY to know when the bus is idle. Sits at top level beside the Device instances: each REQ feeds in, each GNT fans out.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- GNT_TIMEOUT, 16: cycles a granted master has to assert FRAME before the grant is withdrawn
- LAT_TIMER, 8: cycles a master keeps GNT during a transfer while others are waiting (latency-timer feature only)
- clk  input  1  bus clock; all state changes on posedge
- rst_n  input  1  asynchronous, active-low reset
- REQ  input  NUM_REQ  per-device request, active low
- FRAME  input  1  bus FRAME, active low
- IRDY  input  1  bus IRDY, active low
- GNT  output  NUM_REQ  per-device grant, active low, at most one bit low
- grant_idx  output  $clog2(NUM_REQ)  index of current/last granted device
- bus_busy  output  1  high while FRAME or IRDY is low (registered)

## Operation
- Bus idle = FRAME high and IRDY high, sampled at posedge.
- States: IDLE, GRANT, BUSY, TURN.
- IDLE: all GNT high. If any REQ low, select the first low REQ searching upward from last_idx+1 (wraps); drive that GNT low, load grant_idx, go GRANT. last_idx updates on each grant.
- GRANT: count cycles.
  - FRAME low -> BUSY.
  - Granted REQ back high before FRAME -> release GNT, IDLE.
  - Count reaches GNT_TIMEOUT -> release GNT, IDLE; device is skipped by the normal rotation.
- BUSY: GNT stays low. When bus idle and FRAME high -> release GNT, go TURN.
- TURN: one cycle all GNT high (bus turnaround), then IDLE. A new grant never issues in the same cycle as a release.
- Round-robin is fair: a device that continuously requests waits at most NUM_REQ-1 grants.
- No bus parking: with no requests all GNT stay high.
- Simultaneous requests: resolved only by the rotation pointer, never by index.
- REQ of an ungranted device changing during BUSY has no effect until IDLE.
- Reset (at any time, including mid-transfer): state IDLE, GNT all 1, grant_idx 0, last_idx NUM_REQ-1 (device 0 wins first), bus_busy 0, counters 0. Takes effect immediately, without a clock.

## Timing
- REQ sampled low at posedge N in IDLE -> GNT low after posedge N+1 (1-cycle latency).
- GNT changes only on posedge. Devices sample it on the following posedge and drive FRAME on negedge.
- Bus goes idle at posedge M in BUSY -> GNT high after posedge M+1. The next GNT can go low no earlier than after posedge M+3.
- Timeout: GNT held exactly GNT_TIMEOUT cycles, then released on the next posedge.
- bus_busy is registered: 1-cycle delay from FRAME/IRDY.

## Configuration
- PCI_ARB_LATENCY_TIMER_EN defined: in BUSY, a counter starts when FRAME goes low.
  - Once it reaches LAT_TIMER while another REQ is low, GNT is released early. This signals the master to finish its current data phase.
  - The FSM still waits for bus idle, then goes to TURN.
- PCI_ARB_LATENCY_TIMER_EN undefined: GNT is held for the whole transaction, and LAT_TIMER is unused.

## Structure
- Package pci_pkg holds:
  - the state enum typedef (IDLE/GRANT/BUSY/TURN)
  - default GNT_TIMEOUT/LAT_TIMER constants
  - shared address/command constants (device addresses, WRITE/READ C_BE codes), so Device and arbiter agree
- One sub-module: pci_rr_picker, a combinational round-robin search from req vector and last_idx to a valid flag plus next index.

## Test plan
- After reset, REQ = 4'b1110 -> GNT = 4'b1110 one cycle later; FRAME low 2 cycles later -> BUSY; FRAME/IRDY high -> GNT = 4'b1111, then TURN, IDLE.
- REQ = 4'b0000 held with each master running a 1-data-phase transfer -> grant order 0,1,2,3,0, one TURN cycle between grants.
- REQ[2] low, FRAME never asserted -> GNT[2] low for exactly 16 cycles, then high. The next request from device 3 is granted ahead of device 2.
- REQ[1] low then high before FRAME -> GNT[1] released next cycle, FSM in IDLE.
- rst_n low during BUSY with GNT[3] low -> GNT = 4'b1111 immediately (async). After release, REQ = 4'b0000 -> device 0 granted first.
- With PCI_ARB_LATENCY_TIMER_EN, device 0 runs a long burst with REQ[1] low -> GNT[0] high 8 cycles after FRAME low; device 1 is granted only after bus idle plus TURN.
